// File: rtl/mod_unit.sv
// Multi-cycle unsigned remainder unit (result = a mod b) for the ALU mod operation.
// Restoring shift-subtract: one quotient bit per clock, fixed WIDTH iterations.
module mod_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_bit,
   output logic             div_by_zero
);

   // Bit 0 marks CALC and bit 1 marks DONE, so busy/done come straight off the state flops.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] CALC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q,    state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q,  divisor_d;
   logic [WIDTH-1:0] rem_q,      rem_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic             zero_q,     zero_d;
   logic             dbz_q,      dbz_d;

   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] new_rem_s;

   // Next-state and datapath for one shift-subtract iteration.
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      zero_d     = zero_q;
      dbz_d      = dbz_q;

      // Extra top bit of trial_s is the borrow: set means divisor did not fit.
      shifted_s = {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
      trial_s   = {1'b0, shifted_s} - {1'b0, divisor_q};
      new_rem_s = trial_s[WIDTH] ? shifted_s : trial_s[WIDTH-1:0];

      case (state_q)
         IDLE: begin
            if (start) begin
               if (b != {WIDTH{1'b0}}) begin
                  dividend_d = a;
                  divisor_d  = b;
                  rem_d      = {WIDTH{1'b0}};
                  cnt_d      = {CNT_W{1'b0}};
                  state_d    = CALC;
               end else begin
                  result_d = a;
                  zero_d   = (a == {WIDTH{1'b0}});
                  dbz_d    = 1'b1;
                  state_d  = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            rem_d      = new_rem_s;
            dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = new_rem_s;
               zero_d   = (new_rem_s == {WIDTH{1'b0}});
               dbz_d    = 1'b0;
               state_d  = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight operation.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q    <= IDLE;
         dividend_q <= {WIDTH{1'b0}};
         divisor_q  <= {WIDTH{1'b0}};
         rem_q      <= {WIDTH{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         result_q   <= {WIDTH{1'b0}};
         zero_q     <= 1'b1;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = state_q[0];
   assign done        = state_q[1];
   assign result      = result_q;
   assign zero_bit    = zero_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mod_unit.sv
// Directed bench for mod_unit: reset state, remainders, divide-by-zero, ignored start, mid-op reset.
module tb_mod_unit;

   logic        CLK;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero_bit;
   logic        div_by_zero;

   int tests;
   int failed;
   int done_cnt;
   int done_at;
   int busy_cnt;

   mod_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .zero_bit    (zero_bit),
      .div_by_zero (div_by_zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Full normal-case transaction: accept, 31 busy cycles, done on edge 32, low on edge 33.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic exp_zero);
      int early;
      a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0000_0000;
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      early = 0;
      for (int i = 1; i < 32; i++) begin
         tick();
         if (done || !busy) early++;
      end
      chk({tag, "_calc"}, early, 32'd0);
      tick();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busyd"}, {31'd0, busy}, 32'd0);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_zero"}, {31'd0, zero_bit}, {31'd0, exp_zero});
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
      tick();
      chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      tests = 0; failed = 0;
      reset = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_res", result, 32'd0);
      chk("rst_zero", {31'd0, zero_bit}, 32'd1);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

      run_op("m100_7", 32'd100, 32'd7, 32'd2, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      chk("hold_res", result, 32'd2);
      chk("hold_done", {31'd0, done}, 32'd0);

      run_op("m5_9", 32'd5, 32'd9, 32'd5, 1'b0);
      run_op("mff_10", 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0);
      run_op("mff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
      run_op("m8000_3", 32'h8000_0000, 32'd3, 32'd2, 1'b0);

      // Divide by zero: done straight after the accepting edge, never busy.
      a = 32'h1234; b = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("dz_done", {31'd0, done}, 32'd1);
      chk("dz_busy", {31'd0, busy}, 32'd0);
      chk("dz_res", result, 32'h1234);
      chk("dz_dbz", {31'd0, div_by_zero}, 32'd1);
      chk("dz_zero", {31'd0, zero_bit}, 32'd0);
      tick();
      chk("dz_done_lo", {31'd0, done}, 32'd0);

      // Start during CALC is ignored: one done at edge 32 with the first operands.
      a = 32'd100; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt = 0; done_at = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 10) begin
            a = 32'd50; b = 32'd6; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            done_cnt++;
            done_at = i;
         end
      end
      start = 1'b0;
      chk("ign_cnt", done_cnt, 32'd1);
      chk("ign_at", done_at, 32'd32);
      chk("ign_res", result, 32'd2);

      // Reset at cycle 15 abandons the operation.
      a = 32'd100; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      reset = 1'b0;
      tick();
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_res", result, 32'd0);
      chk("mrst_zero", {31'd0, zero_bit}, 32'd1);
      reset = 1'b1;
      done_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done) done_cnt++;
         if (busy) busy_cnt++;
      end
      chk("mrst_nodone", done_cnt, 32'd0);
      chk("mrst_nobusy", busy_cnt, 32'd0);
      run_op("m9_4", 32'd9, 32'd4, 32'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
